sap1_datapath: RTL and testbench



---
 rtl/sap1_datapath_if.sv | 26 ++
 rtl/sap1_datapath.sv | 143 ++++++++++++++
 tb/tb_sap1_datapath.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_datapath_if.sv
// Control/program-load/status bundle between the SAP-1 sequencer side and the datapath.
interface sap1_datapath_if;
  logic [14:0] ctrl;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  out_reg;
  logic        flag_c;
  logic        flag_z;
  logic        bus_conflict;
  logic [3:0]  dbg_pc;
  logic [7:0]  dbg_a;

  // Sequencer / loader side: drives control and program-load, observes status.
  modport master (
    output ctrl, prog_we, prog_addr, prog_data,
    input  opcode, out_reg, flag_c, flag_z, bus_conflict, dbg_pc, dbg_a
  );

  // Datapath side.
  modport slave (
    input  ctrl, prog_we, prog_addr, prog_data,
    output opcode, out_reg, flag_c, flag_z, bus_conflict, dbg_pc, dbg_a
  );
endinterface

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, MDR, RAM, IR, A, B, add/sub ALU and output register
// around a single 8-bit bus driven by the 15-bit control word.
module sap1_datapath #(
  parameter int unsigned RAM_DEPTH = 16,
  parameter logic [7:0]  BUS_IDLE  = 8'h00
) (
  input  logic           clk,
  input  logic           rst_n,
  sap1_datapath_if.slave dp
);

  // Decoded control lines, all active-high internally.
  logic c_p, e_p, l_p, l_ma, l_md, ce, l_r, l_i, e_i, l_a, e_a, s_u, e_u, l_b, l_o;

  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] mdr;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out_q;
  logic       flag_c_q;
  logic       flag_z_q;
  logic [7:0] ram [RAM_DEPTH];

  logic [7:0] bus;
  logic [7:0] b_operand;
  logic [8:0] alu;
  logic [2:0] src_count;

  // Control word decode; _N bits are inverted here so the rest reads naturally.
  always_comb begin
    c_p  =  dp.ctrl[14];
    e_p  =  dp.ctrl[13];
    l_p  =  dp.ctrl[12];
    l_ma = ~dp.ctrl[11];
    l_md = ~dp.ctrl[10];
    ce   = ~dp.ctrl[9];
    l_r  = ~dp.ctrl[8];
    l_i  = ~dp.ctrl[7];
    e_i  = ~dp.ctrl[6];
    l_a  = ~dp.ctrl[5];
    e_a  =  dp.ctrl[4];
    s_u  =  dp.ctrl[3];
    e_u  =  dp.ctrl[2];
    l_b  = ~dp.ctrl[1];
    l_o  = ~dp.ctrl[0];
  end

  // Adder/subtractor; subtract is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    b_operand = s_u ? ~b : b;
    alu       = {1'b0, a} + {1'b0, b_operand} + {8'b0, s_u};
  end

  // Bus multiplexer with fixed source priority E_U > E_A > CE > E_I > E_P.
  always_comb begin
    bus = BUS_IDLE;
    if (e_u)
      bus = alu[7:0];
    else if (e_a)
      bus = a;
    else if (ce)
      bus = ram[mar];
    else if (e_i)
      bus = {4'h0, ir[3:0]};
    else if (e_p)
      bus = {4'h0, pc};
  end

  // Count enabled bus sources to flag contention.
  always_comb begin
    src_count = {2'b0, e_u} + {2'b0, e_a} + {2'b0, ce} + {2'b0, e_i} + {2'b0, e_p};
  end

  // Program counter: a load takes precedence over increment.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pc <= '0;
    else if (l_p)
      pc <= bus[3:0];
    else if (c_p)
      pc <= pc + 4'd1;
  end

  // Memory address and data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (l_ma) mar <= bus[3:0];
      if (l_md) mdr <= bus;
    end
  end

  // Instruction, accumulator, B and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      out_q <= '0;
    end else begin
      if (l_i) ir    <= bus;
      if (l_a) a     <= bus;
      if (l_b) b     <= bus;
      if (l_o) out_q <= bus;
    end
  end

  // Flags track only accumulator loads that come straight from the ALU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (l_a && e_u) begin
      flag_c_q <= alu[8];
      flag_z_q <= (alu[7:0] == 8'h00);
    end
  end

  // RAM writes: the program-load port is issued last so it wins on an address
  // clash with a datapath store; different addresses both land.
  always_ff @(posedge clk) begin
    if (rst_n && l_r)
      ram[mar] <= mdr;
    if (dp.prog_we)
      ram[dp.prog_addr] <= dp.prog_data;
  end

  // Status outputs.
  always_comb begin
    dp.opcode       = ir[7:4];
    dp.out_reg      = out_q;
    dp.flag_c       = flag_c_q;
    dp.flag_z       = flag_z_q;
    dp.bus_conflict = (src_count > 3'd1);
    dp.dbg_pc       = pc;
    dp.dbg_a        = a;
  end

endmodule

// File: tb/tb_sap1_datapath.sv
// Self-checking bench for sap1_datapath: directed program snippets plus random
// control words, compared against a behavioural model of the machine.
module tb_sap1_datapath;

  localparam logic [14:0] IDLE = 15'b000111111100011;
  // Toggling a bit of IDLE asserts that control line (active-high or _N alike).
  localparam logic [14:0] M_CP = 15'h1 << 14;
  localparam logic [14:0] M_EP = 15'h1 << 13;
  localparam logic [14:0] M_LP = 15'h1 << 12;
  localparam logic [14:0] M_LMA = 15'h1 << 11;
  localparam logic [14:0] M_LMD = 15'h1 << 10;
  localparam logic [14:0] M_CE = 15'h1 << 9;
  localparam logic [14:0] M_LR = 15'h1 << 8;
  localparam logic [14:0] M_LI = 15'h1 << 7;
  localparam logic [14:0] M_EI = 15'h1 << 6;
  localparam logic [14:0] M_LA = 15'h1 << 5;
  localparam logic [14:0] M_EA = 15'h1 << 4;
  localparam logic [14:0] M_SU = 15'h1 << 3;
  localparam logic [14:0] M_EU = 15'h1 << 2;
  localparam logic [14:0] M_LB = 15'h1 << 1;
  localparam logic [14:0] M_LO = 15'h1 << 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sap1_datapath_if dpif ();

  sap1_datapath #(.RAM_DEPTH(16), .BUS_IDLE(8'h00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dp   (dpif.slave)
  );

  int total = 0;
  int bad = 0;

  // Behavioural machine state.
  int m_pc, m_mar, m_mdr, m_ir, m_a, m_b, m_out, m_c, m_z;
  int m_ram [16];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc", {5'd0, dpif.dbg_pc}, 9'(m_pc));
    chk("a", {1'b0, dpif.dbg_a}, 9'(m_a));
    chk("opcode", {5'd0, dpif.opcode}, 9'(m_ir / 16));
    chk("out_reg", {1'b0, dpif.out_reg}, 9'(m_out));
    chk("flag_c", {8'd0, dpif.flag_c}, 9'(m_c));
    chk("flag_z", {8'd0, dpif.flag_z}, 9'(m_z));
  endtask

  // One clock: drive at negedge, check the combinational conflict flag, advance
  // the model, then check every registered output at the following negedge.
  task automatic step(input logic rst, input logic [14:0] c, input logic pwe,
                      input logic [3:0] pa, input logic [7:0] pd);
    bit on [5];
    int val [5];
    int nsrc, bus, sum, carry, new_pc;
    bit sub;
    rst_n = rst;
    dpif.ctrl = c;
    dpif.prog_we = pwe;
    dpif.prog_addr = pa;
    dpif.prog_data = pd;
    #1;
    sub = c[3];
    if (sub) begin
      sum = m_a - m_b + 256;
      carry = (m_a >= m_b) ? 1 : 0;
    end else begin
      sum = m_a + m_b;
      carry = (sum > 255) ? 1 : 0;
    end
    sum = sum % 256;
    on[0] = c[2];  val[0] = sum;
    on[1] = c[4];  val[1] = m_a;
    on[2] = !c[9]; val[2] = m_ram[m_mar];
    on[3] = !c[6]; val[3] = m_ir % 16;
    on[4] = c[13]; val[4] = m_pc;
    nsrc = 0;
    bus = 0;
    for (int k = 4; k >= 0; k--) begin
      if (on[k]) begin
        nsrc++;
        bus = val[k];
      end
    end
    chk("bus_conflict", {8'd0, dpif.bus_conflict}, (nsrc >= 2) ? 9'd1 : 9'd0);

    if (!rst) begin
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_z = 0;
    end else begin
      if (!c[8]) m_ram[m_mar] = m_mdr;
      new_pc = m_pc;
      if (c[12]) new_pc = bus % 16;
      else if (c[14]) new_pc = (m_pc + 1) % 16;
      m_pc = new_pc;
      if (!c[11]) m_mar = bus % 16;
      if (!c[10]) m_mdr = bus;
      if (!c[7]) m_ir = bus;
      if (!c[5]) begin
        m_a = bus;
        if (c[2]) begin
          m_c = carry;
          m_z = (sum == 0) ? 1 : 0;
        end
      end
      if (!c[1]) m_b = bus;
      if (!c[0]) m_out = bus;
    end
    if (pwe) m_ram[pa] = pd;

    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input logic [14:0] c);
    step(1'b1, c, 1'b0, 4'h0, 8'h00);
  endtask

  // Put a value in A through RAM at the current MAR.
  task automatic load_a(input logic [7:0] v);
    step(1'b1, IDLE, 1'b1, 4'(m_mar), v);
    run(IDLE ^ M_CE ^ M_LA);
  endtask

  task automatic load_b(input logic [7:0] v);
    step(1'b1, IDLE, 1'b1, 4'(m_mar), v);
    run(IDLE ^ M_CE ^ M_LB);
  endtask

  initial begin
    logic [7:0] v;
    dpif.ctrl = IDLE;
    dpif.prog_we = 1'b0;
    dpif.prog_addr = 4'h0;
    dpif.prog_data = 8'h00;
    @(negedge clk);

    // Reset with garbage control while loading the whole RAM.
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      if (i == 0) v = 8'h4E;
      if (i == 3) v = 8'hA5;
      if (i == 14) v = 8'h37;
      step(1'b0, 15'($urandom), 1'b1, 4'(i), v);
    end
    step(1'b0, 15'($urandom), 1'b0, 4'h0, 8'h00);
    step(1'b0, 15'($urandom), 1'b0, 4'h0, 8'h00);
    chk("rst_pc", {5'd0, dpif.dbg_pc}, 9'h0);
    chk("rst_a", {1'b0, dpif.dbg_a}, 9'h0);
    chk("rst_opcode", {5'd0, dpif.opcode}, 9'h0);
    chk("rst_out", {1'b0, dpif.out_reg}, 9'h0);

    // RAM survives reset: read RAM[3] via PC -> MAR.
    run(IDLE ^ M_CP);
    run(IDLE ^ M_CP);
    run(IDLE ^ M_CP);
    run(IDLE ^ M_EP ^ M_LMA);
    run(IDLE ^ M_CE ^ M_LA);
    chk("ram3_kept", {1'b0, dpif.dbg_a}, 9'hA5);

    // Fetch + LDA 14.
    step(1'b0, 15'($urandom), 1'b0, 4'h0, 8'h00);
    run(IDLE ^ M_EP ^ M_LMA);
    run(IDLE ^ M_CP);
    run(IDLE ^ M_CE ^ M_LI);
    run(IDLE ^ M_EI ^ M_LMA);
    run(IDLE ^ M_CE ^ M_LA);
    chk("lda_opcode", {5'd0, dpif.opcode}, 9'h4);
    chk("lda_pc", {5'd0, dpif.dbg_pc}, 9'h1);
    chk("lda_a", {1'b0, dpif.dbg_a}, 9'h37);

    // ADD with wrap.
    load_a(8'hF0);
    load_b(8'h20);
    run(IDLE ^ M_EU ^ M_LA);
    chk("add_a", {1'b0, dpif.dbg_a}, 9'h10);
    chk("add_c", {8'd0, dpif.flag_c}, 9'h1);
    chk("add_z", {8'd0, dpif.flag_z}, 9'h0);

    // SUB with borrow, then to zero.
    load_a(8'h05);
    load_b(8'h07);
    run(IDLE ^ M_SU ^ M_EU ^ M_LA);
    chk("sub_a", {1'b0, dpif.dbg_a}, 9'hFE);
    chk("sub_c", {8'd0, dpif.flag_c}, 9'h0);
    load_a(8'h07);
    run(IDLE ^ M_SU ^ M_EU ^ M_LA);
    chk("subz_a", {1'b0, dpif.dbg_a}, 9'h00);
    chk("subz_z", {8'd0, dpif.flag_z}, 9'h1);
    chk("subz_c", {8'd0, dpif.flag_c}, 9'h1);

    // STA to RAM[9] then OUT.
    load_a(8'h09);
    run(IDLE ^ M_EA ^ M_LMA);
    load_a(8'h5C);
    step(1'b1, IDLE, 1'b1, 4'h9, 8'h00);
    run(IDLE ^ M_EA ^ M_LMD);
    run(IDLE ^ M_LR);
    run(IDLE ^ M_CE ^ M_LO);
    chk("sta_ram9", {1'b0, dpif.out_reg}, 9'h5C);
    step(1'b1, IDLE, 1'b1, 4'h9, 8'h33);
    run(IDLE ^ M_EA ^ M_LO);
    chk("out_a", {1'b0, dpif.out_reg}, 9'h5C);

    // Bus contention: E_A beats CE.
    step(1'b1, IDLE, 1'b1, 4'h0, 8'h00);
    run(IDLE ^ M_EA ^ M_CE ^ M_LO ^ M_LB);
    chk("conflict_flag", {8'd0, dpif.bus_conflict}, 9'h1);
    chk("conflict_bus", {1'b0, dpif.out_reg}, 9'h5C);

    // PC load beats increment.
    load_a(8'h06);
    run(IDLE ^ M_CP ^ M_LP ^ M_EA);
    chk("pc_load_wins", {5'd0, dpif.dbg_pc}, 9'h6);

    // Program write beats store on the same address (MAR=9).
    run(IDLE ^ M_EA ^ M_LMD);
    step(1'b1, IDLE ^ M_LR, 1'b1, 4'h9, 8'h99);
    run(IDLE ^ M_CE ^ M_LO);
    chk("prog_wins", {1'b0, dpif.out_reg}, 9'h99);

    // Random control, program writes and occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), 15'($urandom), ($urandom_range(0, 3) == 0),
           4'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
